mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit
Interface
REQ-001 SHALL have port: clock  input  1  single system clock, rising edge.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: req_valid in 1, req_write in 1, req_size in 2 (00 byte, 01 half, 10 word, 11 reserved=word), req_signed in 1 (loads only), req_addr in 32, req_wdata in 32: pipeline request.
REQ-004 SHALL have port: req_ready  output  1  high only in IDLE; request accepted when req_valid&req_ready at rising edge.
REQ-005 SHALL have ports: resp_valid out 1 (one-cycle pulse), resp_rdata out 32, resp_err out 1; no response backpressure.
REQ-006 SHALL have ports: mem_address out 32, mem_write_data out 32, mem_Memwrite out 1, mem_read_data in 32: word-wide data-memory side; read data valid one clock after address presented.
Function
REQ-007 SHALL register the accepted request and drive mem_address = {addr[31:2],2'b00}, all from registers.
REQ-008 SHALL implement states IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
REQ-009 IDLE -> LOAD (load), STORE_W (word store), RMW_RD (byte/half store), RESP with error (misaligned, see REQ-019).
REQ-010 LOAD: Memwrite=0; next edge captures lane of mem_read_data -> RESP; load resp_valid 2 cycles after accept.
REQ-011 STORE_W: mem_write_data=wdata, Memwrite=1 for exactly one cycle -> RESP; resp 2 cycles after accept.
REQ-012 RMW_RD: Memwrite=0, read word; RMW_WR: Memwrite=1, write read word with selected lane(s) replaced by wdata[7:0] or wdata[15:0] -> RESP; resp 3 cycles after accept.
REQ-013 Lane select little-endian: byte lane = addr[1:0], half lane = addr[1]; load result sign- or zero-extended per req_signed; word loads ignore req_signed.
REQ-014 RESP: resp_valid=1 one cycle, resp_rdata = load data (0 for stores/errors), then IDLE; back-to-back requests accepted from the following cycle.
REQ-015 mem_Memwrite SHALL never be high outside STORE_W/RMW_WR; exactly one write per store, none per load or error.
REQ-016 Request inputs SHALL be ignored when req_ready=0.
Reset
REQ-017 reset_n=0 at an edge SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_Memwrite=0, mem_address=0, mem_write_data=0, regardless of state.
REQ-018 Reset mid-operation SHALL abort the transaction with no response; a write already issued in a prior cycle is not undone.
Configuration
REQ-019 With MEM_ACCESS_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> RESP next cycle (1 cycle after accept), resp_err=1, no memory access.
REQ-020 Without the macro: low address bits ignored for that size (half uses addr[1], word uses none), access proceeds normally, resp_err tied 0.
Structure
REQ-021 Package mem_access_pkg SHALL hold size encodings (SIZE_B/SIZE_H/SIZE_W), state enum type, and lane-mask constants.
REQ-022 Combinational sub-module mem_lane_align SHALL provide load extract/extend and store merge; FSM and registers stay in mem_access_unit.
Verification
REQ-023 Preload word 0x0000_0010 = 0x8877_6655; lb addr 0x13 signed -> resp_rdata 0xFFFF_FF88 at accept+2; lbu -> 0x0000_0088.
REQ-024 sb wdata 0x0000_00AA addr 0x11 -> one Memwrite at accept+2 with data 0x8877_AA55; resp_valid at accept+3; no other write.
REQ-025 sw 0xDEAD_BEEF addr 0x20 then immediate lw 0x20 -> Memwrite one cycle, lw resp_rdata 0xDEAD_BEEF; req_ready low between accept and RESP.
REQ-026 lh addr 0x11 with macro -> resp_err=1 at accept+1, no memory access; without macro -> resp_rdata 0x0000_6655 sign-extended (0x0000_6655), resp_err=0.
REQ-027 reset_n low during RMW_RD of sh -> no Memwrite, no resp_valid, req_ready=1 next cycle; all outputs at REQ-017 values.

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_access_if.sv | 40 ++++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// the controller state type, byte-lane masks and the alignment helper.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STORE_W = 3'd2,
        ST_RMW_RD  = 3'd3,
        ST_RMW_WR  = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_W = 32'hFFFF_FFFF;

    // Reserved size 2'b11 behaves as a word, so any size with bit 1 set
    // needs both low address bits clear.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_H) begin
            bad = addrLow[0];
        end else if (size[1]) begin
            bad = (addrLow != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bundle of the request/response handshake and the word-wide data-memory
// port. The slave view belongs to mem_access_unit; the master view is the
// requester plus memory side.
interface mem_access_if;
    import mem_access_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_Memwrite;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_Memwrite,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_Memwrite,
        output mem_read_data
    );

endinterface

// File: rtl/mem_lane_align.sv
// Purely combinational little-endian lane logic: pulls a byte/half out of a
// memory word with sign or zero extension, and merges store data into the
// word that was read for a read-modify-write.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdWord_i,
    input  logic [1:0]  addrLow_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] loadData_o,
    output logic [31:0] storeWord_o
);

    logic [4:0]  byteShift;
    logic [4:0]  halfShift;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] laneMask;
    logic [31:0] laneIns;

    // Select the addressed lane, then extend it or splice new data into it.
    always_comb begin
        byteShift = {addrLow_i, 3'b000};
        halfShift = {addrLow_i[1], 4'b0000};
        laneByte  = rdWord_i[byteShift +: 8];
        laneHalf  = rdWord_i[halfShift +: 16];
        loadData_o = rdWord_i;
        laneMask   = LANE_MASK_W;
        laneIns    = wdata_i;
        case (size_i)
            SIZE_B: begin
                loadData_o = {{24{signed_i & laneByte[7]}}, laneByte};
                laneMask   = LANE_MASK_B << byteShift;
                laneIns    = {24'h000000, wdata_i[7:0]} << byteShift;
            end
            SIZE_H: begin
                loadData_o = {{16{signed_i & laneHalf[15]}}, laneHalf};
                laneMask   = LANE_MASK_H << halfShift;
                laneIns    = {16'h0000, wdata_i[15:0]} << halfShift;
            end
            default: begin
                loadData_o = rdWord_i;
                laneMask   = LANE_MASK_W;
                laneIns    = wdata_i;
            end
        endcase
        storeWord_o = (rdWord_i & ~laneMask) | (laneIns & laneMask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a single-outstanding request pipeline and a
// word-wide data memory. Sub-word stores are done as read-modify-write.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to answer misaligned
// half/word requests with resp_err instead of performing the access.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    mem_access_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic        memWrite_q, memWrite_d;
    logic        respValid_q, respValid_d;
    logic [31:0] respRdata_q, respRdata_d;
    logic        respErr_q, respErr_d;

    logic [31:0] loadData;
    logic [31:0] storeWord;
    logic        trapReq;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trapReq = isMisaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign trapReq = 1'b0;
`endif

    mem_lane_align u_lane (
        .rdWord_i    (bus.mem_read_data),
        .addrLow_i   (addr_q[1:0]),
        .size_i      (size_q),
        .signed_i    (signed_q),
        .wdata_i     (wdata_q),
        .loadData_o  (loadData),
        .storeWord_o (storeWord)
    );

    assign bus.req_ready      = (state_q == ST_IDLE);
    assign bus.mem_address    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_data = memWdata_q;
    assign bus.mem_Memwrite   = memWrite_q;
    assign bus.resp_valid     = respValid_q;
    assign bus.resp_rdata     = respRdata_q;
    assign bus.resp_err       = respErr_q;

    // Next-state logic; write enable and response fields default low so they pulse.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        signed_d    = signed_q;
        memWdata_d  = memWdata_q;
        memWrite_d  = 1'b0;
        respValid_d = 1'b0;
        respRdata_d = 32'h0;
        respErr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    if (trapReq) begin
                        state_d     = ST_RESP;
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                    end else if (!bus.req_write) begin
                        state_d = ST_LOAD;
                    end else if (bus.req_size[1]) begin
                        state_d    = ST_STORE_W;
                        memWdata_d = bus.req_wdata;
                        memWrite_d = 1'b1;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                state_d     = ST_RESP;
                respValid_d = 1'b1;
                respRdata_d = loadData;
            end
            ST_STORE_W: begin
                state_d     = ST_RESP;
                respValid_d = 1'b1;
            end
            ST_RMW_RD: begin
                state_d    = ST_RMW_WR;
                memWdata_d = storeWord;
                memWrite_d = 1'b1;
            end
            ST_RMW_WR: begin
                state_d     = ST_RESP;
                respValid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= SIZE_B;
            signed_q    <= 1'b0;
            memWdata_q  <= 32'h0;
            memWrite_q  <= 1'b0;
            respValid_q <= 1'b0;
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            memWdata_q  <= memWdata_d;
            memWrite_q  <= memWrite_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed requests, a transaction
// level reference model, a per-cycle compare process and literal spot checks.
// Works with or without MEM_ACCESS_MISALIGN_TRAP_EN defined.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic preload = 1'b1;
    bit   checking = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    mem_access_if bus();

    mem_access_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] initWord(input int i);
        if (i == 4) return 32'h8877_6655;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Word memory seen by the DUT: combinational read, written on Memwrite.
    logic [31:0] physMem [0:63];
    int wrCount;
    assign bus.mem_read_data = physMem[bus.mem_address[7:2]];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) physMem[i] <= initWord(i);
            wrCount <= 0;
        end else if (bus.mem_Memwrite) begin
            physMem[bus.mem_address[7:2]] <= bus.mem_write_data;
            wrCount <= wrCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: one transaction at a time, timed in cycles since accept.
    logic [31:0] refMem [0:63];
    bit          expReady = 1'b1, expRespValid, expErr, expWrite, expAddrValid, justReset;
    logic [31:0] expRdata, expAddr, expWdata;

    initial begin
        bit          active, wasReady, tErr, tStore;
        int          k, lat, wrAt, nb, lo;
        logic [31:0] tRdata, tWord, old, a, d;
        logic [5:0]  idx;
        logic [1:0]  sz;
        active = 0; k = 0; lat = 0; wrAt = 0; tErr = 0; tStore = 0;
        tRdata = 0; tWord = 0; idx = 0;
        forever begin
            @(posedge clock);
            if (preload) for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
            if (!reset_n) begin
                active = 0; justReset = 1; expReady = 1; expRespValid = 0;
                expErr = 0; expRdata = 0; expWrite = 0; expAddrValid = 0;
            end else begin
                wasReady  = expReady;
                justReset = 0;
                if (active) begin
                    k++;
                    if (k > lat) active = 0;
                end
                if (wasReady && bus.req_valid) begin
                    a = bus.req_addr; d = bus.req_wdata; sz = bus.req_size;
                    idx = a[7:2]; old = refMem[idx];
                    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                    lo = (sz == 2'd0) ? int'(a[1:0]) : (sz == 2'd1) ? 2 * int'(a[1]) : 0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    tErr = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
                    tErr = 0;
`endif
                    active = 1; k = 1; tRdata = 0; tStore = 0; wrAt = 0;
                    expAddr = {a[31:2], 2'b00};
                    if (tErr) begin
                        lat = 1;
                    end else if (!bus.req_write) begin
                        lat = 2;
                        for (int b = 0; b < nb; b++) tRdata[8*b +: 8] = old[8*(lo+b) +: 8];
                        if (bus.req_signed && nb < 4 && tRdata[8*nb-1])
                            for (int b = nb; b < 4; b++) tRdata[8*b +: 8] = 8'hFF;
                    end else begin
                        tStore = 1;
                        tWord  = old;
                        for (int b = 0; b < nb; b++) tWord[8*(lo+b) +: 8] = d[8*b +: 8];
                        lat  = (nb == 4) ? 2 : 3;
                        wrAt = lat - 1;
                    end
                end
                expReady     = !active;
                expRespValid = active && (k == lat);
                expErr       = expRespValid && tErr;
                expRdata     = expRespValid ? tRdata : 32'h0;
                expWrite     = active && tStore && (k == wrAt);
                expWdata     = tWord;
                expAddrValid = active && !tErr;
                if (expWrite) refMem[idx] = tWord;
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                checkOutput("req_ready", bus.req_ready, expReady);
                checkOutput("resp_valid", bus.resp_valid, expRespValid);
                checkOutput("resp_err", bus.resp_err, expErr);
                checkOutput("mem_Memwrite", bus.mem_Memwrite, expWrite);
                if (expRespValid || justReset) checkOutput("resp_rdata", bus.resp_rdata, expRdata);
                if (expWrite) checkOutput("mem_write_data", bus.mem_write_data, expWdata);
                if (expAddrValid) checkOutput("mem_address", bus.mem_address, expAddr);
                if (justReset) begin
                    checkOutput("reset mem_address", bus.mem_address, 32'h0);
                    checkOutput("reset mem_write_data", bus.mem_write_data, 32'h0);
                end
            end
        end
    end

    task automatic applyStimulus(input bit write, input logic [1:0] size, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bit accepted;
        accepted = 0;
        @(posedge clock); #2;
        bus.req_valid = 1; bus.req_write = write; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                @(posedge clock); #2;
                accepted = 1;
            end
        end
        if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
        bus.req_valid = 0;
    endtask

    task automatic checkResp(input string name, input int lat, input logic [31:0] rdata, input logic err);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            checkOutput({name, " req_ready low"}, bus.req_ready, 32'd0);
            if (k < lat) begin
                checkOutput({name, " no early resp"}, bus.resp_valid, 32'd0);
            end else begin
                checkOutput({name, " resp_valid"}, bus.resp_valid, 32'd1);
                checkOutput({name, " resp_rdata"}, bus.resp_rdata, rdata);
                checkOutput({name, " resp_err"}, bus.resp_err, 32'(err));
            end
        end
    endtask

    task automatic waitResp(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clock);
            if (bus.resp_valid) seen = 1;
        end
        if (!seen) checkOutput({name, " resp timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          w;
        logic [1:0]  s;
        bit          g;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        int wrBase;
        vecs = '{
            '{0, SIZE_H,   0, 32'h16, 32'h0},
            '{0, SIZE_W,   1, 32'h13, 32'h0},
            '{1, SIZE_H,   0, 32'h13, 32'h0000_BEEF},
            '{0, SIZE_B,   1, 32'h12, 32'h0},
            '{0, SIZE_H,   1, 32'h12, 32'h0},
            '{1, SIZE_B,   0, 32'h2B, 32'h1234_56C3},
            '{0, SIZE_B,   1, 32'h2B, 32'h0},
            '{0, SIZE_RSV, 0, 32'h28, 32'h0}
        };
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        @(posedge clock); #2;
        checking = 1;
        repeat (2) @(posedge clock);
        #2;
        preload = 0;
        reset_n = 1;

        @(negedge clock);
        checkOutput("reset req_ready", bus.req_ready, 32'd1);
        checkOutput("reset resp_valid", bus.resp_valid, 32'd0);
        checkOutput("reset mem_Memwrite", bus.mem_Memwrite, 32'd0);
        checkOutput("reset mem_address lit", bus.mem_address, 32'h0);

        wrBase = wrCount;
        applyStimulus(0, SIZE_B, 1, 32'h13, 32'h0);
        checkResp("lb 0x13", 2, 32'hFFFF_FF88, 0);
        applyStimulus(0, SIZE_B, 0, 32'h13, 32'h0);
        checkResp("lbu 0x13", 2, 32'h0000_0088, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        applyStimulus(0, SIZE_H, 1, 32'h11, 32'h0);
        checkResp("lh 0x11 trap", 1, 32'h0, 1);
`else
        applyStimulus(0, SIZE_H, 1, 32'h11, 32'h0);
        checkResp("lh 0x11", 2, 32'h0000_6655, 0);
`endif
        checkOutput("loads write count", 32'(wrCount - wrBase), 32'd0);

        // Byte store with a conflicting request held while busy.
        wrBase = wrCount;
        applyStimulus(1, SIZE_B, 0, 32'h11, 32'h0000_00AA);
        bus.req_valid = 1; bus.req_write = 1; bus.req_size = SIZE_W;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h5555_5555;
        @(negedge clock);
        checkOutput("sb write at +1", bus.mem_Memwrite, 32'd0);
        @(negedge clock);
        checkOutput("sb write at +2", bus.mem_Memwrite, 32'd1);
        checkOutput("sb write data", bus.mem_write_data, 32'h8877_AA55);
        checkOutput("sb write addr", bus.mem_address, 32'h0000_0010);
        @(negedge clock);
        checkOutput("sb resp at +3", bus.resp_valid, 32'd1);
        checkOutput("sb write gone", bus.mem_Memwrite, 32'd0);
        bus.req_valid = 0;
        checkOutput("sb write count", 32'(wrCount - wrBase), 32'd1);

        applyStimulus(0, SIZE_H, 1, 32'h12, 32'h0);
        checkResp("lh 0x12", 2, 32'hFFFF_8877, 0);

        wrBase = wrCount;
        applyStimulus(1, SIZE_W, 0, 32'h20, 32'hDEAD_BEEF);
        checkResp("sw 0x20", 2, 32'h0, 0);
        applyStimulus(0, SIZE_W, 1, 32'h20, 32'h0);
        checkResp("lw 0x20", 2, 32'hDEAD_BEEF, 0);
        checkOutput("sw/lw write count", 32'(wrCount - wrBase), 32'd1);

        applyStimulus(1, SIZE_H, 0, 32'h16, 32'hCAFE_1234);
        checkResp("sh 0x16", 3, 32'h0, 0);
        applyStimulus(0, SIZE_W, 0, 32'h14, 32'h0);
        checkResp("lw 0x14", 2, 32'h1234_0505, 0);

        applyStimulus(1, SIZE_RSV, 0, 32'h28, 32'h0BAD_F00D);
        checkResp("s-rsv 0x28", 2, 32'h0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].w, vecs[i].s, vecs[i].g, vecs[i].a, vecs[i].d);
            waitResp($sformatf("vec%0d", i));
        end

        // Reset while a half store sits in its read phase.
        wrBase = wrCount;
        applyStimulus(1, SIZE_H, 0, 32'h24, 32'h0000_7777);
        reset_n = 0;
        @(posedge clock); #2;
        reset_n = 1;
        @(negedge clock);
        checkOutput("abort req_ready", bus.req_ready, 32'd1);
        checkOutput("abort resp_valid", bus.resp_valid, 32'd0);
        checkOutput("abort resp_err", bus.resp_err, 32'd0);
        checkOutput("abort resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("abort mem_Memwrite", bus.mem_Memwrite, 32'd0);
        checkOutput("abort mem_address", bus.mem_address, 32'h0);
        checkOutput("abort mem_write_data", bus.mem_write_data, 32'h0);
        repeat (3) @(negedge clock);
        checkOutput("abort write count", 32'(wrCount - wrBase), 32'd0);
        checkOutput("abort word intact", physMem[9], initWord(9));

        applyStimulus(0, SIZE_B, 0, 32'h10, 32'h0);
        checkResp("lbu 0x10 after abort", 2, 32'h0000_0055, 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
